// File: rtl/addsub_accum_ctrl.sv
// Accumulator controller around a WIDTH-bit ripple adder/subtractor.
// One operation per upstream handshake; the result is presented downstream on valid/ready.
module addsub_accum_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // state | meaning
  // IDLE  | no pending op, ready to accept
  // EXEC  | adder evaluated on acc and latched operand, result written this cycle
  // HOLD  | result valid downstream, held until consumed
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             add_ovf;
  logic             accept;

  // Ripple adder: SUB inverts B and injects the +1 through the carry-in.
  always_comb begin
    b_eff = (op_q == OP_SUB) ? ~operand_q : operand_q;
    sum   = '0;
    c     = '0;
    c[0]  = (op_q == OP_SUB);
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = acc_q[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (acc_q[i] & b_eff[i]) | (c[i] & (acc_q[i] ^ b_eff[i]));
    end
    add_ovf = (acc_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != acc_q[WIDTH-1]);
  end

  always_comb begin
    in_ready  = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
    accept    = in_valid & in_ready;
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op;
          operand_d = operand;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_HOLD;
        case (op_q)
          OP_LOAD: begin
            acc_d   = operand_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_d   = sum;
            carry_d = c[WIDTH];
            ovf_d   = add_ovf;
          end
          OP_CLEAR: begin
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          default: ;
        endcase
      end
      ST_HOLD: begin
        // Consuming and accepting on the same edge keeps throughput at one op per 2 cycles.
        if (out_ready) begin
          if (accept) begin
            op_d      = op;
            operand_d = operand;
            state_d   = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = (acc_q == '0);

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Self-checking bench for addsub_accum_ctrl: directed scenarios plus randomized ops
// checked against an integer-arithmetic reference model.
module tb_addsub_accum_ctrl;
  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, carry, overflow, zero;
  logic [1:0] op;
  logic [W-1:0] operand, acc;

  int n_checks = 0;
  int n_pass = 0;
  int m_acc = 0;
  bit m_carry = 1'b0;
  bit m_ovf = 1'b0;

  addsub_accum_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand(operand), .out_valid(out_valid), .out_ready(out_ready), .acc(acc),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_signed(int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_apply(input logic [1:0] o, input int v);
    int d;
    case (o)
      LOAD: begin m_acc = v; m_carry = 0; m_ovf = 0; end
      CLR:  begin m_acc = 0; m_carry = 0; m_ovf = 0; end
      ADD: begin
        d = to_signed(m_acc) + to_signed(v);
        m_ovf = (d > MOD / 2 - 1) || (d < -MOD / 2);
        m_carry = (m_acc + v) >= MOD;
        m_acc = (m_acc + v) % MOD;
      end
      default: begin
        d = to_signed(m_acc) - to_signed(v);
        m_ovf = (d > MOD / 2 - 1) || (d < -MOD / 2);
        m_carry = (m_acc >= v);
        m_acc = (m_acc - v + MOD) % MOD;
      end
    endcase
  endtask

  // Waits for in_ready, presents one op, and returns once the result is in HOLD.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] v);
    int t = 0;
    out_ready = 1'b1;
    while (!in_ready && t < 20) begin step(); t++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL do_op_timeout in_ready=%b exp=1", in_ready);
      return;
    end
    in_valid = 1'b1; op = o; operand = v;
    step();
    in_valid = 1'b0; op = 2'($urandom); operand = W'($urandom);
    model_apply(o, int'(v));
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = LOAD; operand = '0;
    step(); step();
    n_checks++; if (acc !== 4'h0) $display("FAIL rst_acc acc=%h exp=0", acc); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("FAIL rst_zero zero=%b exp=1", zero); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid out_valid=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready in_ready=%b exp=0", in_ready); else n_pass++;
    n_checks++; if ({carry, overflow} !== 2'b00) $display("FAIL rst_flags c/o=%b%b exp=00", carry, overflow); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready in_ready=%b exp=1", in_ready); else n_pass++;
    m_acc = 0; m_carry = 0; m_ovf = 0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid = 1'b1; op = LOAD; operand = 4'h5;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_exec out_valid=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL lat_exec_in_ready in_ready=%b exp=0", in_ready); else n_pass++;
    step();
    model_apply(LOAD, 5);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL lat_hold out_valid=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (acc !== 4'h5) $display("FAIL load5 acc=%h exp=5", acc); else n_pass++;
  endtask

  task automatic test_add_overflow();
    do_op(ADD, 4'h3);
    n_checks++; if ({acc, carry, overflow, zero} !== {4'h8, 3'b010})
      $display("FAIL add_5_3 acc/c/o/z=%h/%b/%b/%b exp=8/0/1/0", acc, carry, overflow, zero); else n_pass++;
  endtask

  task automatic test_sub();
    do_op(LOAD, 4'h8);
    do_op(SUB, 4'h8);
    n_checks++; if ({acc, carry, overflow, zero} !== {4'h0, 3'b101})
      $display("FAIL sub_8_8 acc/c/o/z=%h/%b/%b/%b exp=0/1/0/1", acc, carry, overflow, zero); else n_pass++;
    do_op(SUB, 4'h1);
    n_checks++; if ({acc, carry, overflow, zero} !== {4'hF, 3'b000})
      $display("FAIL sub_0_1 acc/c/o/z=%h/%b/%b/%b exp=F/0/0/0", acc, carry, overflow, zero); else n_pass++;
  endtask

  task automatic test_wrap_and_clear();
    do_op(LOAD, 4'hF);
    do_op(ADD, 4'h1);
    n_checks++; if ({acc, carry, overflow, zero} !== {4'h0, 3'b101})
      $display("FAIL wrap_F_1 acc/c/o/z=%h/%b/%b/%b exp=0/1/0/1", acc, carry, overflow, zero); else n_pass++;
    do_op(LOAD, 4'h7);
    do_op(CLR, 4'h9);
    n_checks++; if ({acc, carry, overflow, zero} !== {4'h0, 3'b001})
      $display("FAIL clear acc/c/o/z=%h/%b/%b/%b exp=0/0/0/1", acc, carry, overflow, zero); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_op(LOAD, 4'h3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 2'($urandom); operand = W'($urandom);
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready cyc=%0d in_ready=%b exp=0", i, in_ready); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b1 || acc !== 4'h3)
        $display("FAIL hold_stable cyc=%0d out_valid=%b acc=%h exp=1/3", i, out_valid, acc); else n_pass++;
    end
    out_ready = 1'b1; in_valid = 1'b1; op = ADD; operand = 4'h2;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready in_ready=%b exp=1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    model_apply(ADD, 2);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_consumed out_valid=%b exp=0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || acc !== 4'h5)
      $display("FAIL b2b_result out_valid=%b acc=%h exp=1/5", out_valid, acc); else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    do_op(LOAD, 4'h6);
    out_ready = 1'b1; in_valid = 1'b1; op = ADD; operand = 4'h4;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    n_checks++; if (acc !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rst_exec acc=%h out_valid=%b in_ready=%b exp=0/0/0", acc, out_valid, in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_exec_idle in_ready=%b exp=1", in_ready); else n_pass++;
    m_acc = 0; m_carry = 0; m_ovf = 0;
  endtask

  task automatic test_random();
    int stall;
    logic [1:0] o;
    logic [W-1:0] v;
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom);
      v = W'($urandom);
      do_op(o, v);
      n_checks++; if (acc !== W'(m_acc) || carry !== m_carry || overflow !== m_ovf || zero !== (m_acc == 0) || out_valid !== 1'b1)
        $display("FAIL rand_%0d op=%0d b=%h acc/c/o/z/v=%h/%b/%b/%b/%b exp=%h/%b/%b/%b/1",
                 n, o, v, acc, carry, overflow, zero, out_valid, W'(m_acc), m_carry, m_ovf, m_acc == 0);
      else n_pass++;
      stall = $urandom_range(0, 2);
      if (stall != 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) step();
        n_checks++; if (acc !== W'(m_acc) || out_valid !== 1'b1)
          $display("FAIL rand_stall_%0d acc=%h out_valid=%b exp=%h/1", n, acc, out_valid, W'(m_acc));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_add_overflow();
    test_sub();
    test_wrap_and_clear();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
